morse_keyer: RTL and testbench

- Downstream consumer of the ASCII text ROM in the Morse transmitter.
- On `start`, walks the ROM from address 0 and reads one character per fetch over the ROM's `cs`/`adr`/`data` interface.
- Translates each character to ITU Morse and drives a single keying line (`key`) with unit-based dot/dash/gap timing.
- Stops at a 0x00 terminator or at the last ROM address.

---
 rtl/morse_keyer.sv | 128 ++++++++++++
 tb/tb_morse_keyer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/morse_keyer.sv
// morse_keyer: reads ASCII text from ROM and keys it out as ITU Morse with unit-based timing
module morse_keyer #(
  parameter int UNIT_CYCLES = 50000,
  parameter int ADR_W = 16,
  parameter int MAX_ADR = 4095
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             rom_cs,
  output logic [ADR_W-1:0] rom_adr,
  input  logic [7:0]       rom_data,
  output logic             key,
  output logic             busy,
  output logic             done,
  output logic [7:0]       cur_char
);
  localparam int TW = $clog2(4 * UNIT_CYCLES);
  localparam logic [TW-1:0] T1 = TW'(UNIT_CYCLES - 1);
  localparam logic [TW-1:0] T2 = TW'(2 * UNIT_CYCLES - 1);
  localparam logic [TW-1:0] T3 = TW'(3 * UNIT_CYCLES - 1);
  localparam logic [TW-1:0] T4 = TW'(4 * UNIT_CYCLES - 1);
  typedef enum logic [3:0] {IDLE, FETCH, WAIT, LATCH, DECODE, MARK, SPACE, LGAP, WGAP, DONE} state_t;
  state_t state, state_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [2:0] cnt, cnt_n;
  logic [4:0] pat, pat_n;
  logic [7:0] chr_n, code;
  logic [ADR_W-1:0] adr_n;
  logic alnum, last, adv;
  // {element count, pattern left-justified with first element in bit 4, 1 = dash}
  function automatic logic [7:0] lookup(input logic [7:0] c);
    case (c)
      "A": lookup = 8'b010_01000;  "B": lookup = 8'b100_10000;  "C": lookup = 8'b100_10100;
      "D": lookup = 8'b011_10000;  "E": lookup = 8'b001_00000;  "F": lookup = 8'b100_00100;
      "G": lookup = 8'b011_11000;  "H": lookup = 8'b100_00000;  "I": lookup = 8'b010_00000;
      "J": lookup = 8'b100_01110;  "K": lookup = 8'b011_10100;  "L": lookup = 8'b100_01000;
      "M": lookup = 8'b010_11000;  "N": lookup = 8'b010_10000;  "O": lookup = 8'b011_11100;
      "P": lookup = 8'b100_01100;  "Q": lookup = 8'b100_11010;  "R": lookup = 8'b011_01000;
      "S": lookup = 8'b011_00000;  "T": lookup = 8'b001_10000;  "U": lookup = 8'b011_00100;
      "V": lookup = 8'b100_00010;  "W": lookup = 8'b011_01100;  "X": lookup = 8'b100_10010;
      "Y": lookup = 8'b100_10110;  "Z": lookup = 8'b100_11000;
      "0": lookup = 8'b101_11111;  "1": lookup = 8'b101_01111;  "2": lookup = 8'b101_00111;
      "3": lookup = 8'b101_00011;  "4": lookup = 8'b101_00001;  "5": lookup = 8'b101_00000;
      "6": lookup = 8'b101_10000;  "7": lookup = 8'b101_11000;  "8": lookup = 8'b101_11100;
      "9": lookup = 8'b101_11110;
      default: lookup = 8'h00;
    endcase
  endfunction
  assign code = lookup(cur_char);
  assign alnum = (cur_char >= 8'h41 && cur_char <= 8'h5A) || (cur_char >= 8'h30 && cur_char <= 8'h39);
  assign last = rom_adr == ADR_W'(MAX_ADR);
  always_comb begin
    state_n = state;
    adr_n = rom_adr;
    tmr_n = (tmr == '0) ? tmr : tmr - TW'(1);
    cnt_n = cnt;
    pat_n = pat;
    chr_n = cur_char;
    adv = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = FETCH;
        adr_n = '0;
      end
      FETCH: state_n = WAIT;
      WAIT: state_n = LATCH;
      LATCH: begin
        chr_n = (rom_data >= 8'h61 && rom_data <= 8'h7A) ? rom_data - 8'h20 : rom_data;
        state_n = DECODE;
      end
      DECODE: if (cur_char == 8'h00) state_n = DONE;
        else if (cur_char == 8'h20) begin
          state_n = WGAP;
          tmr_n = T4;
        end else if (alnum) begin
          state_n = MARK;
          cnt_n = code[7:5];
          pat_n = code[4:0];
          tmr_n = code[4] ? T3 : T1;
        end else adv = 1'b1;
      MARK: if (tmr == '0) begin
        state_n = SPACE;
        tmr_n = T1;
        cnt_n = cnt - 3'd1;
        pat_n = {pat[3:0], 1'b0};
      end
      SPACE: if (tmr == '0) begin
        state_n = (cnt != 3'd0) ? MARK : LGAP;
        tmr_n = (cnt != 3'd0) ? (pat[4] ? T3 : T1) : T2;
      end
      LGAP, WGAP: adv = tmr == '0;
      DONE: begin
        state_n = IDLE;
        chr_n = 8'h00;
      end
      default: state_n = IDLE;
    endcase
    if (adv) begin
      state_n = last ? DONE : FETCH;
      adr_n = last ? rom_adr : rom_adr + ADR_W'(1);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tmr <= '0;
      cnt <= '0;
      pat <= '0;
      rom_adr <= '0;
      cur_char <= '0;
      rom_cs <= 1'b0;
      key <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      tmr <= tmr_n;
      cnt <= cnt_n;
      pat <= pat_n;
      rom_adr <= adr_n;
      cur_char <= chr_n;
      rom_cs <= state_n != IDLE;
      key <= state_n == MARK;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
    end
endmodule

// File: tb/tb_morse_keyer.sv
// tb_morse_keyer: random/directed text runs; expected key waveform built from Morse timing rules
module tb_morse_keyer;
  localparam int U = 2;
  localparam int MAX = 3;
  logic clk = 0, rst = 1, start = 0;
  logic rom_cs, key, busy, done;
  logic [15:0] rom_adr;
  logic [7:0] rom_data, cur_char, rd;
  logic [7:0] mem [4];
  typedef struct {int lvl; int len; int ch;} seg_t;
  seg_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  int m_lvl = 0, m_len = 0, m_ch = 0;
  bit mon_en = 1;
  string lt[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---", "-.-", ".-..", "--",
                    "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
  string dg[10] = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."};

  morse_keyer #(.UNIT_CYCLES(U), .ADR_W(16), .MAX_ADR(MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_cs(rom_cs), .rom_adr(rom_adr), .rom_data(rom_data),
    .key(key), .busy(busy), .done(done), .cur_char(cur_char));

  always #5 clk = ~clk;
  always @(posedge clk) if (rom_cs) rd <= (rom_adr < 16'd4) ? mem[rom_adr[1:0]] : 8'hFF;
  assign rom_data = rom_cs ? rd : 8'h00;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // expected key waveform as alternating low/high runs, then a done marker (lvl 2)
  function automatic void model(output int last);
    int low = 4;
    int a;
    logic [7:0] c;
    string m;
    for (a = 0; a <= MAX; a++) begin
      c = mem[a];
      if (c >= "a" && c <= "z") c = c - 8'd32;
      if (c == 8'h00) break;
      if (c == " ") low += 4 * U;
      else if ((c >= "A" && c <= "Z") || (c >= "0" && c <= "9")) begin
        m = (c >= "A") ? lt[int'(c) - 65] : dg[int'(c) - 48];
        for (int i = 0; i < m.len(); i++) begin
          exp_q.push_back('{0, low, 0});
          exp_q.push_back('{1, (m[i] == "-") ? 3 * U : U, int'(c)});
          low = U;
        end
        low += 2 * U;
      end
      if (a == MAX) break;
      low += 4;
    end
    last = a;
    exp_q.push_back('{0, low, 0});
    exp_q.push_back('{2, 0, 0});
  endfunction

  task automatic close_seg();
    seg_t e;
    if (exp_q.size() == 0) check("seg_extra", m_len, 0);
    else begin
      e = exp_q.pop_front();
      check("seg_lvl", m_lvl, e.lvl);
      check("seg_len", m_len, e.len);
      if (e.lvl == 1) check("seg_chr", m_ch, e.ch);
    end
  endtask

  task automatic close_done();
    seg_t e;
    close_seg();
    if (exp_q.size() == 0) check("done_extra", 1, 0);
    else begin
      e = exp_q.pop_front();
      check("done_pos", 2, e.lvl);
    end
  endtask

  always @(negedge clk) begin
    if (!mon_en || rst || !busy) begin
      m_lvl = 0;
      m_len = 0;
    end else if (done) begin
      close_done();
      m_lvl = 0;
      m_len = 0;
    end else if (int'(key) != m_lvl) begin
      close_seg();
      m_lvl = int'(key);
      m_len = 1;
      m_ch = int'(cur_char);
    end else m_len++;
  end

  task automatic load(input string s);
    for (int i = 0; i < 4; i++) mem[i] = (i < s.len()) ? s[i] : 8'h00;
  endtask

  task automatic wait_done(input bit poke);
    bit seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (poke) start = ($urandom_range(0, 7) == 0);
    end
    if (poke) start = 0;
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic run(input bit poke, input bit hold);
    int last;
    model(last);
    if (hold) model(last);
    start = 1;
    @(negedge clk);
    if (!hold) start = 0;
    wait_done(poke);
    if (hold) begin
      @(negedge clk);
      check("hold_idle_busy", busy, 0);
      @(negedge clk);
      start = 0;
      check("hold_restart_busy", busy, 1);
      check("hold_restart_cs", rom_cs, 1);
      wait_done(0);
    end
    @(negedge clk);
    check("end_busy", busy, 0);
    check("end_cs", rom_cs, 0);
    check("end_key", key, 0);
    check("end_char", cur_char, 0);
    check("end_done", done, 0);
    check("end_adr", rom_adr, last);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    string pool = "ABEKQTYZaeqz059 #,";
    load("");
    repeat (2) @(negedge clk);
    check("rst_key", key, 0);
    check("rst_cs", rom_cs, 0);
    check("rst_adr", rom_adr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_char", cur_char, 0);
    rst = 0;
    @(negedge clk);
    load("E");    run(0, 0);
    load("ET");   run(0, 0);
    load("e#5");  run(0, 0);
    load("A A");  run(0, 0);
    load("TTTT"); run(0, 0);
    mon_en = 0;
    load("T");
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 30 && !key; i++) @(negedge clk);
    check("mark_seen", key, 1);
    rst = 1;
    #1;
    check("arst_key", key, 0);
    check("arst_cs", rom_cs, 0);
    check("arst_busy", busy, 0);
    check("arst_char", cur_char, 0);
    @(negedge clk);
    rst = 0;
    mon_en = 1;
    @(negedge clk);
    load("E");    run(0, 0);
    load("K9");   run(1, 0);
    load("ET");   run(0, 1);
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 4; i++)
        mem[i] = ($urandom_range(0, 5) == 0) ? 8'h00 : pool[$urandom_range(0, pool.len() - 1)];
      run($urandom_range(0, 1) == 1, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
